// File: rtl/spi_response_tx_if.sv
// SPI pin bundle between host (master) and response transmitter (slave).
// Mode 0 link: host drives SCLK/CS_N, slave drives MISO and its enable.
interface spi_response_tx_if;
   logic spi_sclk;
   logic spi_cs_n;
   logic spi_miso;
   logic spi_miso_oe;

   modport master (
      output spi_sclk,
      output spi_cs_n,
      input  spi_miso,
      input  spi_miso_oe
   );

   modport slave (
      input  spi_sclk,
      input  spi_cs_n,
      output spi_miso,
      output spi_miso_oe
   );
endinterface

// File: rtl/spi_response_tx.sv
// SPI-slave mode 0 response transmitter: one {status, result} byte per host byte.
// Define RESP_SEQ_EN to interleave an 8-bit sequence counter on odd bytes.
module spi_response_tx #(
   parameter int          SYNC_STAGES      = 2,
   parameter logic [3:0]  NO_RESULT_NIBBLE = 4'hF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_response_tx_if.slave       spi,
   input  logic [3:0]             status_code,
   input  logic                   result_valid,
   input  logic [3:0]             result_out,
   output logic                   tx_busy,
   output logic                   byte_sent
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LOAD  = 2'b01,
      S_SHIFT = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sclk_q;
   logic                   cs_q;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_fall;

   logic [2:0]             bit_cnt;
   logic [7:0]             tx_sr;
   logic [7:0]             snapshot;
   logic [7:0]             next_byte;
   logic                   wrap;
   logic                   reload;

   // Idle values: SCLK low, CS deasserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_fall   = ~cs_s & cs_q;

   assign snapshot = {status_code,
                      result_valid ? result_out : NO_RESULT_NIBBLE};

   assign wrap   = (state == S_SHIFT) && sclk_rise && (bit_cnt == 3'd7);
   assign reload = (state == S_SHIFT) && !cs_s && sclk_fall
                   && (bit_cnt == 3'd0);

`ifdef RESP_SEQ_EN
   logic       odd;
   logic [7:0] seq_cnt;

   // Counter survives frames; only the byte parity restarts per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         odd     <= 1'b0;
         seq_cnt <= 8'h00;
      end else begin
         if (state == S_LOAD)
            odd <= 1'b0;
         else if (reload)
            odd <= ~odd;
         if (wrap && !odd)
            seq_cnt <= seq_cnt + 8'h01;
      end
   end

   assign next_byte = odd ? snapshot : seq_cnt;
`else
   assign next_byte = snapshot;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cs_fall) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = cs_s ? S_IDLE : S_SHIFT;
         S_SHIFT: if (cs_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd0;
         tx_sr     <= 8'h00;
         byte_sent <= 1'b0;
      end else begin
         byte_sent <= wrap;
         if (state == S_LOAD) begin
            tx_sr   <= snapshot;
            bit_cnt <= 3'd0;
         end else if (state == S_SHIFT) begin
            if (cs_s)
               bit_cnt <= 3'd0;
            else if (sclk_rise)
               bit_cnt <= bit_cnt + 3'd1;
            else if (sclk_fall) begin
               if (bit_cnt != 3'd0)
                  tx_sr <= {tx_sr[6:0], 1'b0};
               else
                  tx_sr <= next_byte;
            end
         end
      end
   end

   assign tx_busy         = (state != S_IDLE);
   assign spi.spi_miso    = tx_busy & tx_sr[7];
   assign spi.spi_miso_oe = tx_busy;

endmodule
